// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

  // Nibble shown for out-of-range values; the 7-seg decoder renders it as "-".
  localparam logic [3:0] BCD_DASH = 4'hF;

  // Largest value representable in the given number of decimal digits.
  function automatic int max_bcd_val(input int digits);
    int v;
    v = 1;
    for (int i = 0; i < digits; i++) v = v * 10;
    return v - 1;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction for one BCD nibble: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Values above the display range come out as all-dash digits with overflow set.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter  int W      = 14,
  parameter  int DIGITS = 4,
  localparam int MAXVAL = max_bcd_val(DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + W;
  localparam int CW = $clog2(W + 1);

  // The input must be wide enough to hold every displayable value, which also
  // guarantees MAXVAL fits in W bits for the range compare below.
  if (W < $clog2(MAXVAL + 1)) begin : g_width_check
    $fatal(1, "bin_to_bcd_seq: W too small for DIGITS");
  end

  localparam logic [W-1:0] MAX_W = W'(MAXVAL);

  conv_state_t   state;
  logic [SW-1:0] sr;
  logic [CW-1:0] cnt;
  logic          ovf_q;
  logic [BW-1:0] adj;
  logic [SW-1:0] sr_next;

  // Per-digit add-3 correction on the BCD field of the shift register.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (sr[W + 4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  // Corrected BCD field above the untouched binary field, shifted left one bit.
  assign sr_next = {adj, sr[W-1:0]} << 1;

  // Control FSM and datapath registers; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      ovf_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sr    <= {{BW{1'b0}}, bin};
            cnt   <= CW'(W);
            ovf_q <= (bin > MAX_W);
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sr  <= sr_next;
          cnt <= cnt - CW'(1);
          // Last bit shifted in: publish the result from the post-shift value.
          if (cnt == CW'(1)) begin
            state    <= DONE;
            bcd      <= ovf_q ? {DIGITS{BCD_DASH}} : sr_next[SW-1 -: BW];
            overflow <= ovf_q;
            done     <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the per-digit BCD-to-7-segment decoders.
- Converts a binary count or value into DIGITS packed BCD nibbles, one nibble per display digit.
- Values outside the display range are presented as dash codes; the decoder's default case renders these as "-".

Parameters:
- W, 14, width of the binary input.
- DIGITS, 4, number of BCD output digits.
- MAXVAL, 10**DIGITS-1, largest representable value (derived; do not override).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  conversion request; sampled only in IDLE.
- bin  in  W  binary value; captured on the edge that accepts start.
- busy  out  1  high from the edge after acceptance until the edge that returns to IDLE.
- done  out  1  one-cycle registered pulse when bcd/overflow are updated.
- bcd  out  4*DIGITS  packed result; nibble 0 (bits 3:0) is the least-significant digit. Holds its value between conversions.
- overflow  out  1  high when the last converted bin exceeded MAXVAL.

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs): state=IDLE, busy=0, done=0, bcd=0, overflow=0, internal shift register and counter cleared.
- Reset mid-conversion aborts the conversion. No done pulse is produced, and bcd is cleared to 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge k: load shift register with {4*DIGITS zeros, bin}, load counter=W, latch ovf_q = (bin > MAXVAL).
  - Go to SHIFT. busy=1 from edge k.
  - start=0: stay in IDLE.
- SHIFT (edges k+1 .. k+W):
  - Each edge: every BCD nibble >= 5 gets +3 (each nibble evaluated independently, 4-bit result, no carry between nibbles).
  - Then the whole register shifts left by 1, and the counter decrements.
  - On the edge where counter goes 1->0 (edge k+W): go to DONE; load bcd from the BCD field (or all 4'hF if ovf_q); load overflow=ovf_q; assert done.
- DONE: lasts exactly one cycle. Next edge (k+W+1): done=0, busy=0, state=IDLE. A new start is accepted no earlier than edge k+W+2.
- Latency: done is high in the cycle following edge k+W, i.e. W edges after acceptance. For W=14 this is 14 edges; throughput is one conversion per W+2 cycles.
- start while busy (SHIFT or DONE) is ignored and not queued. bin changes after acceptance have no effect.
- Overflow: bin > MAXVAL gives bcd = all nibbles 4'hF and overflow=1. bin == MAXVAL converts normally.
- bin=0: bcd=0, overflow=0, latency unchanged.
- Internal shift register width is 4*DIGITS+W. The counter width is $clog2(W+1).
- Elaboration check: W must be >= $clog2(MAXVAL+1), else fatal.

Decomposition:
- Shared package bcd_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t
  - constant BCD_DASH = 4'hF
  - localparam function computing 10**DIGITS-1
- One sub-module, bcd_add3: combinational, 4-bit in / 4-bit out, adds 3 when input >= 5. Instantiated DIGITS times in a generate loop inside the SHIFT datapath.

Test Plan:
- Reset, then bin=14'd1234, start pulsed one cycle: busy stays high 15 cycles; done pulses once 14 edges after acceptance; bcd=16'h1234, overflow=0.
- bin=9999: bcd=16'h9999, overflow=0. Then bin=10000: bcd=16'hFFFF, overflow=1, with identical latency.
- bin=0, then bin=5, then bin=90 back-to-back, each start issued the first cycle after busy drops: bcd=16'h0000, 16'h0005, 16'h0090; exactly three done pulses.
- start=1 held continuously with bin changing every cycle from 7 to 8 after acceptance: result 16'h0007. Next conversion accepted only at edge k+16, and it captures the bin present on that edge.
- reset asserted at the 6th SHIFT edge of a bin=4321 conversion: next edge shows busy=0, done=0, bcd=0, state IDLE; no done pulse follows. A subsequent start with bin=4321 gives 16'h4321.
- Exhaustive sweep bin=0..16383 with DIGITS=4: bcd matches a reference model for every value ≤ 9999; every value ≥ 10000 gives 16'hFFFF with overflow=1.
